cvxif_table_decoder: RTL

- Second-generation CV-X-IF coprocessor front end. The instruction/mask decode table is a bank of NbEntries runtime-programmable registers, not a compile-time constant array.
- Accepted instructions are buffered with their operands in a FifoDepth-deep issue queue. They are released to the execution unit only after the core commits them; killed instructions are dropped.
- Sits between the CVA6 CV-X-IF issue/commit interface and the coprocessor datapath (e.g. the ROR64 and ASCON units).

---
 rtl/cvxif_table_decoder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cvxif_table_decoder.sv
// CV-X-IF coprocessor front end: programmable decode table plus an
// in-order issue queue that releases committed instructions.
module cvxif_table_decoder #(
  parameter int unsigned NbEntries = 16,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned NrRs      = 3,
  parameter int unsigned XLEN      = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         cfg_we_i,
  input  logic [$clog2(NbEntries)-1:0] cfg_idx_i,
  input  logic                         cfg_en_i,
  input  logic [31:0]                  cfg_instr_i,
  input  logic [31:0]                  cfg_mask_i,
  input  logic [3:0]                   cfg_opcode_i,
  input  logic                         cfg_wb_i,
  input  logic [NrRs-1:0]              cfg_rr_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [31:0]                  issue_instr_i,
  input  logic [IdWidth-1:0]           issue_id_i,
  input  logic [NrRs*XLEN-1:0]         issue_rs_i,
  input  logic [NrRs-1:0]              issue_rs_valid_i,
  output logic                         issue_accept_o,
  output logic                         issue_writeback_o,
  output logic [NrRs-1:0]              issue_register_read_o,
  input  logic                         commit_valid_i,
  input  logic [IdWidth-1:0]           commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [3:0]                   out_opcode_o,
  output logic [IdWidth-1:0]           out_id_o,
  output logic [4:0]                   out_rd_o,
  output logic                         out_we_o,
  output logic [NrRs*XLEN-1:0]         out_rs_o,
  output logic [$clog2(FifoDepth):0]   count_o
);

  localparam int unsigned IW = $clog2(NbEntries);
  localparam int unsigned PW = $clog2(FifoDepth);
  localparam int unsigned CW = PW + 1;

  // decode table
  logic [NbEntries-1:0] tv_q, tv_d;
  logic [31:0]          ti_q [NbEntries];
  logic [31:0]          ti_d [NbEntries];
  logic [31:0]          tm_q [NbEntries];
  logic [31:0]          tm_d [NbEntries];
  logic [3:0]           to_q [NbEntries];
  logic [3:0]           to_d [NbEntries];
  logic [NbEntries-1:0] tw_q, tw_d;
  logic [NrRs-1:0]      tr_q [NbEntries];
  logic [NrRs-1:0]      tr_d [NbEntries];

  // issue queue
  logic [IdWidth-1:0]   qid_q [FifoDepth];
  logic [IdWidth-1:0]   qid_d [FifoDepth];
  logic [3:0]           qop_q [FifoDepth];
  logic [3:0]           qop_d [FifoDepth];
  logic [4:0]           qrd_q [FifoDepth];
  logic [4:0]           qrd_d [FifoDepth];
  logic [NrRs*XLEN-1:0] qrs_q [FifoDepth];
  logic [NrRs*XLEN-1:0] qrs_d [FifoDepth];
  logic [FifoDepth-1:0] qwe_q, qwe_d;
  logic [FifoDepth-1:0] qc_q, qc_d;
  logic [FifoDepth-1:0] qk_q, qk_d;
  logic [FifoDepth-1:0] occ;

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;

  logic                 hit;
  logic [IW-1:0]        hit_idx;
  logic [NrRs-1:0]      rr_sel;
  logic                 ops_ok;
  logic                 full;
  logic                 enq;
  logic                 pop;
  logic                 same_cmt;
  logic [NrRs*XLEN-1:0] rs_m;

  always_comb begin
    tv_d = tv_q;
    ti_d = ti_q;
    tm_d = tm_q;
    to_d = to_q;
    tw_d = tw_q;
    tr_d = tr_q;
    if (cfg_we_i) begin
      tv_d[cfg_idx_i] = cfg_en_i;
      ti_d[cfg_idx_i] = cfg_instr_i;
      tm_d[cfg_idx_i] = cfg_mask_i;
      to_d[cfg_idx_i] = cfg_opcode_i;
      tw_d[cfg_idx_i] = cfg_wb_i;
      tr_d[cfg_idx_i] = cfg_rr_i;
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NbEntries; k++) begin
      if (!hit && tv_q[k] &&
          ((issue_instr_i & tm_q[k]) == ti_q[k])) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  assign rr_sel = tr_q[hit_idx];
  assign ops_ok = (issue_rs_valid_i & rr_sel) == rr_sel;
  assign full   = count_q == CW'(FifoDepth);

  assign issue_ready_o = !rst_i && (!hit || (!full && ops_ok));
  assign issue_accept_o = hit && issue_ready_o;
  assign issue_writeback_o = issue_accept_o && tw_q[hit_idx];
  assign issue_register_read_o =
    issue_accept_o ? rr_sel : '0;

  assign enq = issue_valid_i && issue_accept_o && !flush_i;
  assign same_cmt = commit_valid_i && (commit_id_i == issue_id_i);

  always_comb begin
    rs_m = '0;
    for (int j = 0; j < NrRs; j++) begin
      if (rr_sel[j])
        rs_m[j*XLEN +: XLEN] = issue_rs_i[j*XLEN +: XLEN];
    end
  end

  // slot i is live when its distance from the head is below the count
  always_comb begin
    occ = '0;
    for (int i = 0; i < FifoDepth; i++)
      occ[i] = CW'(PW'(PW'(i) - rptr_q)) < count_q;
  end

  assign pop = (count_q != '0) && qc_q[rptr_q] &&
               (qk_q[rptr_q] || (out_valid_q && out_ready_i));

  always_comb begin
    qid_d = qid_q;
    qop_d = qop_q;
    qrd_d = qrd_q;
    qrs_d = qrs_q;
    qwe_d = qwe_q;
    qc_d  = qc_q;
    qk_d  = qk_q;
    for (int i = 0; i < FifoDepth; i++) begin
      if (occ[i] && commit_valid_i && qid_q[i] == commit_id_i) begin
        qc_d[i] = 1'b1;
        qk_d[i] = commit_kill_i;
      end
    end
    if (enq) begin
      qid_d[wptr_q] = issue_id_i;
      qop_d[wptr_q] = to_q[hit_idx];
      qrd_d[wptr_q] = issue_instr_i[11:7];
      qrs_d[wptr_q] = rs_m;
      qwe_d[wptr_q] = tw_q[hit_idx];
      qc_d[wptr_q]  = same_cmt;
      qk_d[wptr_q]  = same_cmt && commit_kill_i;
    end
    wptr_d  = wptr_q + PW'(enq);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(enq) - CW'(pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    out_valid_d = (count_d != '0) && qc_d[rptr_d] && !qk_d[rptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tv_q        <= '0;
      qc_q        <= '0;
      qk_q        <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      tv_q        <= tv_d;
      qc_q        <= qc_d;
      qk_q        <= qk_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // payload storage needs no reset; validity lives in the flops above
  always_ff @(posedge clk_i) begin
    ti_q  <= ti_d;
    tm_q  <= tm_d;
    to_q  <= to_d;
    tw_q  <= tw_d;
    tr_q  <= tr_d;
    qid_q <= qid_d;
    qop_q <= qop_d;
    qrd_q <= qrd_d;
    qrs_q <= qrs_d;
    qwe_q <= qwe_d;
  end

  assign out_valid_o  = out_valid_q;
  assign out_opcode_o = qop_q[rptr_q];
  assign out_id_o     = qid_q[rptr_q];
  assign out_rd_o     = qrd_q[rptr_q];
  assign out_we_o     = qwe_q[rptr_q];
  assign out_rs_o     = qrs_q[rptr_q];
  assign count_o      = count_q;

endmodule
